// File: rtl/fifo_read_arbiter_if.sv
// Read-side bundle between the FIFO, its consumers and the read arbiter.
// Consumers and the FIFO flag drive the master side; the arbiter is the slave.
interface fifo_read_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 8
);
    localparam int ID_W = $clog2(N_REQ);

    logic [N_REQ-1:0] read_en;
    logic             empty;
    logic [N_REQ-1:0] valid;
    logic             pop;
    logic [ID_W-1:0]  grant_id;
    logic             busy;
    logic             timeout_err;
    logic [CNT_W-1:0] pop_cnt;

    modport master (
        output read_en, empty,
        input  valid, pop, grant_id, busy, timeout_err, pop_cnt
    );

    modport slave (
        input  read_en, empty,
        output valid, pop, grant_id, busy, timeout_err, pop_cnt
    );
endinterface

// File: rtl/fifo_read_arbiter.sv
// Round-robin arbiter sharing one FIFO read port among N_REQ consumers,
// with a hold-timeout guard and a wrapping count of completed pops.
//
// state | meaning
// IDLE  | waiting for a request while the FIFO is non-empty
// HS    | valid shown to the granted consumer until it drops read_en
// POP   | one-cycle FIFO pop, pop count advances, pointer rotates
// ABORT | consumer held too long: timeout_err pulse, no pop, pointer rotates
module fifo_read_arbiter #(
    parameter int N_REQ  = 4,
    parameter int TO_CYC = 16,
    parameter int CNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    fifo_read_arbiter_if.slave bus
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int TMR_W = $clog2(TO_CYC);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_HS    = 2'd1;
    localparam logic [1:0] ST_POP   = 2'd2;
    localparam logic [1:0] ST_ABORT = 2'd3;

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  grant_id;
    logic [TMR_W-1:0] timer;
    logic [CNT_W-1:0] pop_cnt;
    logic [ID_W-1:0]  pick;
    logic             pick_ok;
    logic [ID_W-1:0]  next_ptr;

    // First requester at or after rr_ptr, wrapping modulo N_REQ.
    always_comb begin
        logic [ID_W:0] sum;
        pick_ok = 1'b0;
        pick    = rr_ptr;
        sum     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            sum = {1'b0, rr_ptr} + (ID_W + 1)'(i);
            if (sum >= (ID_W + 1)'(N_REQ)) begin
                sum = sum - (ID_W + 1)'(N_REQ);
            end
            if (!pick_ok && bus.read_en[sum[ID_W-1:0]]) begin
                pick_ok = 1'b1;
                pick    = sum[ID_W-1:0];
            end
        end
    end

    assign next_ptr = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + ID_W'(1);

    // The timer counts down from TO_CYC-1; reaching zero while still held aborts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
            timer    <= '0;
            pop_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!bus.empty && pick_ok) begin
                        grant_id <= pick;
                        timer    <= TMR_W'(TO_CYC - 1);
                        state    <= ST_HS;
                    end
                end
                ST_HS: begin
                    if (!bus.read_en[grant_id]) begin
                        state <= ST_POP;
                    end else if (timer == '0) begin
                        state <= ST_ABORT;
                    end else begin
                        timer <= timer - TMR_W'(1);
                    end
                end
                ST_POP: begin
                    pop_cnt <= pop_cnt + CNT_W'(1);
                    rr_ptr  <= next_ptr;
                    state   <= ST_IDLE;
                end
                ST_ABORT: begin
                    rr_ptr <= next_ptr;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.valid       = (state == ST_HS) ? (N_REQ'(1) << grant_id) : '0;
    assign bus.pop         = (state == ST_POP);
    assign bus.busy        = (state != ST_IDLE);
    assign bus.timeout_err = (state == ST_ABORT);
    assign bus.grant_id    = grant_id;
    assign bus.pop_cnt     = pop_cnt;
endmodule

// File: tb/tb_fifo_read_arbiter.sv
// Randomised scoreboard bench for fifo_read_arbiter: a transaction-level model
// predicts each grant, and a negedge monitor checks every valid/pop/abort.
module tb_fifo_read_arbiter;
    localparam int N_REQ  = 4;
    localparam int TO_CYC = 16;
    localparam int CNT_W  = 8;

    typedef struct {
        bit to;
        int id;
        int cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fifo_read_arbiter_if #(.N_REQ(N_REQ), .CNT_W(CNT_W)) bus();

    fifo_read_arbiter #(.N_REQ(N_REQ), .TO_CYC(TO_CYC), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;
    int   m_rr  = 0;
    int   m_cnt = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
        end
    endtask

    // Reference rule: first requesting index at or after the rotation pointer.
    function automatic int model_pick(input logic [N_REQ-1:0] m);
        for (int i = 0; i < N_REQ; i++) begin
            int idx;
            idx = (m_rr + i) % N_REQ;
            if (m[idx]) return idx;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            if (bus.pop || bus.timeout_err) begin
                if (sb.size() == 0) begin
                    chk("unexpected_pop", {bus.pop, bus.timeout_err}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("end_kind", {bus.pop, bus.timeout_err}, mon_e.to ? 2'b01 : 2'b10);
                    chk("end_grant_id", bus.grant_id, mon_e.id);
                    chk("end_pop_cnt", bus.pop_cnt, mon_e.cnt);
                end
            end else if (bus.valid != '0) begin
                if (sb.size() == 0) chk("unexpected_valid", bus.valid, 0);
                else chk("valid_onehot", bus.valid, 64'd1 << sb[0].id);
            end
        end
    end

    // One transfer: starts and ends on a negedge; hold>=TO_CYC means never release.
    task automatic txn(input logic [N_REQ-1:0] mask, input int hold, input int lat);
        int   w, n, h;
        bit   to, done;
        exp_t e;
        w     = model_pick(mask);
        to    = (hold >= TO_CYC);
        e.to  = to;
        e.id  = w;
        e.cnt = m_cnt % (1 << CNT_W);
        sb.push_back(e);
        m_rr = (w + 1) % N_REQ;
        if (!to) m_cnt++;
        bus.read_en = mask;
        bus.empty   = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.valid == '0 && n < 8);
        chk("grant_latency", n, lat);
        if (bus.valid == '0) begin
            sb.delete();
            return;
        end
        h    = 1;
        done = 1'b0;
        for (int k = 0; k < 64 && !done; k++) begin
            if (bus.valid != '0) begin
                if (!to && h >= hold) bus.read_en[w] = 1'b0;
                bus.empty = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            if (bus.pop || bus.timeout_err) done = 1'b1;
            else if (bus.valid != '0) h++;
        end
        chk("txn_done", done, 1);
        chk("valid_cycles", h, to ? TO_CYC : hold);
        if (!done) sb.delete();
    endtask

    task automatic idle_gap();
        bus.read_en = '0;
        bus.empty   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    function automatic int rand_hold();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return TO_CYC;
        if (r == 1) return TO_CYC - 1;
        return $urandom_range(1, 4);
    endfunction

    initial begin
        int lat;
        logic [N_REQ-1:0] m;
        exp_t e;
        bus.read_en = '0;
        bus.empty   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.valid, 0);
        chk("rst_pop", bus.pop, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_timeout", bus.timeout_err, 0);
        chk("rst_pop_cnt", bus.pop_cnt, 0);
        chk("rst_grant_id", bus.grant_id, 0);
        rst = 1'b1;
        @(negedge clk);

        // single requester
        txn(4'b0100, 3, 1);
        idle_gap();
        chk("single_pop_cnt", bus.pop_cnt, m_cnt);

        // full contention, rotating
        txn(4'b1111, 1, 1);
        repeat (4) txn(4'b1111, 1, 2);
        idle_gap();
        chk("contention_pop_cnt", bus.pop_cnt, m_cnt);

        // empty blocks every grant
        bus.empty   = 1'b1;
        bus.read_en = 4'b0011;
        repeat (10) begin
            @(negedge clk);
            chk("empty_block", {bus.busy, bus.valid, bus.pop}, 0);
        end
        txn(4'b0011, 2, 1);
        idle_gap();

        // hold timeout, then rotation past the aborted requester
        txn(4'b0010, 100, 1);
        txn(4'b0110, 1, 2);
        txn(4'b0010, 1, 2);
        chk("timeout_pop_cnt", bus.pop_cnt, m_cnt - 1);

        // random traffic
        lat = 2;
        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle_gap();
                lat = 1;
            end
            m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            txn(m, rand_hold(), lat);
            lat = 2;
        end
        idle_gap();
        chk("random_pop_cnt", bus.pop_cnt, m_cnt % (1 << CNT_W));

        // asynchronous reset in the middle of a handshake
        bus.read_en = 4'b1000;
        e.to  = 1'b0;
        e.id  = model_pick(4'b1000);
        e.cnt = m_cnt % (1 << CNT_W);
        sb.push_back(e);
        @(negedge clk);
        chk("pre_rst_valid", bus.valid, 4'b1000);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", bus.valid, 0);
        chk("async_rst_busy", bus.busy, 0);
        sb.delete();
        m_rr  = 0;
        m_cnt = 0;
        bus.read_en = '0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_pop_cnt", bus.pop_cnt, 0);
        chk("post_rst_grant_id", bus.grant_id, 0);

        // counter wrap
        lat = 1;
        for (int t = 0; t < 256; t++) begin
            m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            txn(m, 1, lat);
            lat = 2;
        end
        idle_gap();
        chk("wrap_256", bus.pop_cnt, m_cnt % (1 << CNT_W));
        txn(4'b0001, 1, 1);
        idle_gap();
        chk("wrap_257", bus.pop_cnt, m_cnt % (1 << CNT_W));
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
